mulu_seq_x6y6_ctrl: RTL and testbench
=====================================

// Module: mulu_seq_x6y6_ctrl
// PURPOSE
//  Sequencer that reuses one external unsigned LIMB_W x LIMB_W combinational multiplier
//  (mulu_x3y3 at default width) to form a full (LIMBS*LIMB_W)-bit x (LIMBS*LIMB_W)-bit product.
//  Each of the LIMBS*LIMBS limb pairs goes through the shared multiplier once; results are
//  shift-accumulated. Sits between a valid/ready operand source and a valid/ready result sink.
// PARAMETERS
//  LIMB_W  3  limb width; must equal the width of the attached multiplier
//  LIMBS   2  limbs per operand; operand width OW = LIMBS*LIMB_W, product width PW = 2*OW
// PORTS
//  clk        in   1         clock, all state updates on rising edge
//  rst        in   1         synchronous reset, active-high
//  in_x       in   OW        operand X (unsigned)
//  in_y       in   OW        operand Y (unsigned)
//  in_valid   in   1         operands valid
//  in_ready   out  1         block can accept operands
//  mul_x      out  LIMB_W    limb of X driven to the shared multiplier
//  mul_y      out  LIMB_W    limb of Y driven to the shared multiplier
//  mul_p      in   2*LIMB_W  combinational product returned by the multiplier, same cycle
//  p          out  PW        full product
//  out_valid  out  1         p is valid
//  out_ready  in   1         sink accepts p
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, acc=0, operand regs=0; in_ready=1, out_valid=0, p=0,
//    mul_x=0, mul_y=0. rst overrides everything, including mid-MUL and DONE; the operation
//    in flight is discarded with no output.
//  - States: IDLE -> MUL -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready: latch in_x/in_y, acc<=0, idx<=0, go MUL.
//  - MUL: in_ready=0. Each cycle: i=idx%LIMBS (X limb), j=idx/LIMBS (Y limb);
//    mul_x=xr[i*LIMB_W +: LIMB_W], mul_y=yr[j*LIMB_W +: LIMB_W] (from registers, glitch-free);
//    acc <= acc + (zero-extended mul_p << LIMB_W*(i+j)); idx<=idx+1.
//    Last cycle (idx==LIMBS*LIMBS-1): go DONE, idx<=0.
//  - mul_x/mul_y = 0 outside MUL.
//  - Arithmetic: acc is PW bits wide. The final sum is exact and cannot overflow
//    (max (2^OW-1)^2 < 2^PW); no truncation is applied.
//  - DONE: out_valid=1, p=acc, held stable while out_ready=0. On out_ready: go IDLE,
//    out_valid<=0. in_ready stays 0 in DONE, so there is no same-cycle accept.
//  - p keeps its last value after DONE until the next result; it is meaningful only
//    while out_valid=1.
//  - Latency: accept edge at cycle 0 -> out_valid=1 after LIMBS*LIMBS edges
//    (4 at default). Max throughput is one result per LIMBS*LIMBS+2 cycles.
//  - in_valid is ignored outside IDLE; the source holds operands until in_ready.
//  - out_ready outside DONE has no effect.
//  - idx counter is ceil(log2(LIMBS*LIMBS)) bits, minimum 1; it never wraps within MUL.
// TESTING
//  Bench models the multiplier as mul_p = mul_x*mul_y (combinational).
//  1 reset: hold rst 2 cycles -> in_ready=1, out_valid=0, p=0, mul_x=mul_y=0.
//  2 basic: in_x=5, in_y=6, out_ready=1 -> out_valid high exactly 4 cycles after accept,
//    p=30; mul_x/mul_y sequence limbs (5,6),(0,6),(5,0),(0,0).
//  3 max: in_x=63, in_y=63 -> p=3969 (0xF81); zero: in_x=0, in_y=42 -> p=0.
//  4 backpressure: out_ready=0 for 3 cycles in DONE -> p and out_valid stable,
//    in_ready=0; on out_ready=1, IDLE the next cycle.
//  5 busy: in_valid pulsed with in_x=7, in_y=7 during MUL -> ignored; result is still
//    the first operands' product.
//  6 reset mid-op: rst in 2nd MUL cycle -> next cycle IDLE, no out_valid; a new
//    operation (9*9) afterwards gives p=81.

Source files
------------

// File: rtl/mulu_seq_x6y6_ctrl_if.sv
// Operand/result handshake bus for the limb-sequenced multiplier, including the
// pins that connect to the shared limb multiplier.
interface mulu_seq_x6y6_ctrl_if #(
  parameter int unsigned LIMB_W = 3,
  parameter int unsigned LIMBS  = 2
);
  localparam int unsigned OW = LIMBS * LIMB_W;
  localparam int unsigned PW = 2 * OW;

  logic [OW-1:0]       in_x;
  logic [OW-1:0]       in_y;
  logic                in_valid;
  logic                in_ready;
  logic [LIMB_W-1:0]   mul_x;
  logic [LIMB_W-1:0]   mul_y;
  logic [2*LIMB_W-1:0] mul_p;
  logic [PW-1:0]       p;
  logic                out_valid;
  logic                out_ready;

  // Environment side: operand source, result sink and the shared multiplier.
  modport master (
    output in_x, in_y, in_valid, mul_p, out_ready,
    input  in_ready, mul_x, mul_y, p, out_valid
  );

  modport slave (
    input  in_x, in_y, in_valid, mul_p, out_ready,
    output in_ready, mul_x, mul_y, p, out_valid
  );
endinterface

// File: rtl/mulu_seq_x6y6_ctrl.sv
// Sequences LIMBS*LIMBS limb pairs through one external LIMB_W x LIMB_W multiplier
// and shift-accumulates the partial products into a full-width unsigned product.
module mulu_seq_x6y6_ctrl #(
  parameter int unsigned LIMB_W = 3,
  parameter int unsigned LIMBS  = 2
) (
  input logic                  clk,
  input logic                  rst,
  mulu_seq_x6y6_ctrl_if.slave  bus
);
  localparam int unsigned OW    = LIMBS * LIMB_W;
  localparam int unsigned PW    = 2 * OW;
  localparam int unsigned NP    = LIMBS * LIMBS;
  localparam int unsigned IDX_W = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [OW-1:0]     xr, yr;
  logic [PW-1:0]     acc, acc_nx;
  logic [PW-1:0]     term_c;
  logic              accept_c, last_c;
  logic              in_ready_r, in_ready_nx;
  logic              out_valid_r, out_valid_nx;
  logic [PW-1:0]     p_r, p_nx;
  logic [LIMB_W-1:0] mul_x_r, mul_x_nx, mul_y_r, mul_y_nx;
  int unsigned       cur_c, nxt_c, sh_c;

  function automatic logic [LIMB_W-1:0] limb(input logic [OW-1:0] v, input int unsigned k);
    return LIMB_W'(v >> (k * LIMB_W));
  endfunction

  assign accept_c = (state == IDLE) && bus.in_valid && in_ready_r;
  assign last_c   = (state == MUL) && (idx == IDX_W'(NP - 1));
  assign cur_c    = 32'(idx);
  assign nxt_c    = cur_c + 1;
  assign sh_c     = LIMB_W * ((cur_c % LIMBS) + (cur_c / LIMBS));
  assign term_c   = PW'(bus.mul_p) << sh_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      xr          <= '0;
      yr          <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      p_r         <= '0;
      mul_x_r     <= '0;
      mul_y_r     <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      acc         <= acc_nx;
      in_ready_r  <= in_ready_nx;
      out_valid_r <= out_valid_nx;
      p_r         <= p_nx;
      mul_x_r     <= mul_x_nx;
      mul_y_r     <= mul_y_nx;
      if (accept_c) begin
        xr <= bus.in_x;
        yr <= bus.in_y;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c)      state_nx = MUL;
      MUL:     if (last_c)        state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; the limb pair for the following cycle
  // is preloaded so mul_x/mul_y come straight from flops.
  always_comb begin
    idx_nx       = idx;
    acc_nx       = acc;
    in_ready_nx  = in_ready_r;
    out_valid_nx = out_valid_r;
    p_nx         = p_r;
    mul_x_nx     = '0;
    mul_y_nx     = '0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          idx_nx      = '0;
          acc_nx      = '0;
          in_ready_nx = 1'b0;
          mul_x_nx    = limb(bus.in_x, 0);
          mul_y_nx    = limb(bus.in_y, 0);
        end
      end
      MUL: begin
        acc_nx = acc + term_c;
        if (last_c) begin
          idx_nx       = '0;
          out_valid_nx = 1'b1;
          p_nx         = acc + term_c;
        end else begin
          idx_nx   = idx + IDX_W'(1);
          mul_x_nx = limb(xr, nxt_c % LIMBS);
          mul_y_nx = limb(yr, nxt_c / LIMBS);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
        end
      end
      default: begin
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.p         = p_r;
  assign bus.mul_x     = mul_x_r;
  assign bus.mul_y     = mul_y_r;
endmodule

// File: tb/tb_mulu_seq_x6y6_ctrl.sv
// Self-checking bench for mulu_seq_x6y6_ctrl: vector table, directed handshake
// corner cases and random operands against a plain x*y product model.
module tb_mulu_seq_x6y6_ctrl;
  localparam int unsigned LIMB_W = 3;
  localparam int unsigned LIMBS  = 2;
  localparam int unsigned OW     = LIMBS * LIMB_W;
  localparam int unsigned PW     = 2 * OW;
  localparam int unsigned LAT    = LIMBS * LIMBS;

  typedef struct {
    logic [OW-1:0] x;
    logic [OW-1:0] y;
    logic [PW-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mulu_seq_x6y6_ctrl_if #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) bus ();

  mulu_seq_x6y6_ctrl #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared multiplier model.
  assign bus.mul_p = (2*LIMB_W)'(bus.mul_x) * (2*LIMB_W)'(bus.mul_y);

  always #5 clk = ~clk;

  logic [LIMB_W-1:0] seen_x [LAT];
  logic [LIMB_W-1:0] seen_y [LAT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Offer operands from IDLE, optionally pulse a bogus request mid-MUL, and wait
  // (bounded) for the result; leaves the DUT in DONE with out_ready low.
  task automatic run_op(input logic [OW-1:0] x, input logic [OW-1:0] y, input bit busy,
                        output logic [PW-1:0] p_got, output int lat);
    @(negedge clk);
    bus.in_x = x; bus.in_y = y; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      if (lat < LAT) begin
        seen_x[lat] = bus.mul_x;
        seen_y[lat] = bus.mul_y;
      end
      if (busy && lat == 1) begin
        bus.in_x = 6'd7; bus.in_y = 6'd7; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    p_got = bus.p;
  endtask

  // Accept the pending result and confirm the return to IDLE.
  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_mul_x", 64'(bus.mul_x), 64'd0);
  endtask

  vec_t          tbl [6];
  logic [PW-1:0] pg, p_hold;
  int            lat;

  initial begin
    tbl[0] = '{x: 6'd5,  y: 6'd6,  p: 12'd30};
    tbl[1] = '{x: 6'd63, y: 6'd63, p: 12'hF81};
    tbl[2] = '{x: 6'd0,  y: 6'd42, p: 12'd0};
    tbl[3] = '{x: 6'd1,  y: 6'd1,  p: 12'd1};
    tbl[4] = '{x: 6'd63, y: 6'd1,  p: 12'd63};
    tbl[5] = '{x: 6'd8,  y: 6'd8,  p: 12'd64};

    rst = 1'b1;
    bus.in_x = '0; bus.in_y = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_p", 64'(bus.p), 64'd0);
    check("rst_mul_x", 64'(bus.mul_x), 64'd0);
    check("rst_mul_y", 64'(bus.mul_y), 64'd0);
    rst = 1'b0;

    // Vector table, including the limb sequence for 5*6.
    for (int k = 0; k < 6; k++) begin
      run_op(tbl[k].x, tbl[k].y, 1'b0, pg, lat);
      check("tbl_latency", 64'(lat), 64'(LAT));
      check("tbl_p", 64'(pg), 64'(tbl[k].p));
      check("done_mul_y", 64'(bus.mul_y), 64'd0);
      if (k == 0) begin
        check("seq0", {32'(seen_x[0]), 32'(seen_y[0])}, {32'd5, 32'd6});
        check("seq1", {32'(seen_x[1]), 32'(seen_y[1])}, {32'd0, 32'd6});
        check("seq2", {32'(seen_x[2]), 32'(seen_y[2])}, {32'd5, 32'd0});
        check("seq3", {32'(seen_x[3]), 32'(seen_y[3])}, {32'd0, 32'd0});
      end
      release_result();
    end

    // Backpressure: result held for 3 cycles with out_ready low.
    run_op(6'd21, 6'd13, 1'b0, pg, lat);
    p_hold = pg;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_p", 64'(bus.p), 64'(p_hold));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    check("bp_value", 64'(p_hold), 64'd273);
    release_result();

    // Request pulsed during MUL must be ignored.
    run_op(6'd11, 6'd3, 1'b1, pg, lat);
    check("busy_p", 64'(pg), 64'd33);
    release_result();
    check("busy_no_second_op", 64'(bus.in_ready), 64'd1);

    // Reset in the second MUL cycle discards the operation.
    @(negedge clk);
    bus.in_x = 6'd5; bus.in_y = 6'd6; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_p", 64'(bus.p), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_valid", 64'(bus.out_valid), 64'd0);
    end
    run_op(6'd9, 6'd9, 1'b0, pg, lat);
    check("midrst_new_p", 64'(pg), 64'd81);
    release_result();

    // Random operands with random backpressure against x*y.
    for (int n = 0; n < 40; n++) begin
      logic [OW-1:0] rx, ry;
      logic [PW-1:0] exp_p;
      int            stall;
      rx    = OW'($urandom);
      ry    = OW'($urandom);
      exp_p = PW'(rx) * PW'(ry);
      stall = int'($urandom_range(0, 2));
      run_op(rx, ry, 1'b0, pg, lat);
      check("rnd_latency", 64'(lat), 64'(LAT));
      check("rnd_p", 64'(pg), 64'(exp_p));
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        check("rnd_hold_p", 64'(bus.p), 64'(exp_p));
      end
      release_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
